// File: rtl/dl_addsub_arbiter.sv
// rtl/dl_addsub_arbiter.sv - round-robin sharing of one registered DLFloat16 add/sub unit
module dl_addsub_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic [15:0]           fu_a,
  output logic [15:0]           fu_b,
  output logic                  fu_op,
  input  logic [19:0]           fu_c_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [19:0]           resp_data,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_last;
  logic             s1_valid, s2_valid;
  logic [ID_W-1:0]  s1_id, s2_id;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [ID_W+19:0] mem [FIFO_DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             credit_ok;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  int unsigned      cand;
  logic             handshake;
  logic             push, pop;

  // Every op already issued still owns a FIFO slot; a pop in this same cycle is not credited.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
  assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_last) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // One-hot ready toward the winner, suppressed during reset or without credit.
  always_comb begin
    req_ready = '0;
    if (!rst && credit_ok && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign handshake = |(req_ready & req_valid);

  // Issue stage: capture winning operands into the unit and start the tag pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      fu_a     <= '0;
      fu_b     <= '0;
      fu_op    <= 1'b0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      rr_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      s1_valid <= handshake;
      if (handshake) begin
        fu_a    <= req_a[16*grant_idx +: 16];
        fu_b    <= req_b[16*grant_idx +: 16];
        fu_op   <= req_op[grant_idx];
        s1_id   <= grant_idx;
        rr_last <= grant_idx;
      end
    end
  end

  // Second tag stage lines up with the unit's registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  assign push = s2_valid;
  assign pop  = resp_valid && resp_ready;

  // Response FIFO pointers and occupancy; credit guarantees no push while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage holds the requester tag alongside the untouched unit result.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {s2_id, fu_c_out};
  end

  assign resp_valid = (fifo_count != '0);
  assign resp_id    = mem[rd_ptr][ID_W+19:20];
  assign resp_data  = mem[rd_ptr][19:0];
  assign busy       = s1_valid || s2_valid || (fifo_count != '0);

endmodule

// File: tb/tb_dl_addsub_arbiter.sv
// tb/tb_dl_addsub_arbiter.sv - self-checking bench for dl_addsub_arbiter
module tb_dl_addsub_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic [N-1:0]    req_op = '0;
  logic [15:0]     fu_a, fu_b;
  logic            fu_op;
  logic [19:0]     fu_c_out = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [19:0]     resp_data;
  logic            busy;

  dl_addsub_arbiter #(.NUM_REQ(N), .ID_W(2), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op), .fu_c_out(fu_c_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in unit: known answers for the plan's operands, an arbitrary tag function otherwise.
  function automatic logic [19:0] fu_fn(input logic [15:0] a, input logic [15:0] b, input logic op);
    if (a == 16'h3E00 && b == 16'h3E00 && !op) return 20'h40800;
    if (a == 16'hFFFF && b == 16'h3E00 && op) return 20'h0FFFF;
    return {op, a ^ {b[14:0], b[15]}, 3'b011};
  endfunction

  always @(posedge clk) fu_c_out <= fu_fn(fu_a, fu_b, fu_op);

  typedef struct {
    int          id;
    logic [19:0] data;
    int          ready;
  } ent_t;

  ent_t        q[$];
  int          m_rr = N - 1;
  int          ecnt = 0;
  logic [15:0] m_fu_a = '0, m_fu_b = '0;
  logic        m_fu_op = 1'b0;
  bit          chk_on = 1'b0;
  int          tests = 0, fails = 0;

  bit          s_rst = 1'b0, s_hs = 1'b0, s_pop = 1'b0;
  int          s_idx = 0;
  logic [15:0] s_a, s_b;
  logic        s_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: every accepted op is outstanding until popped; it becomes visible 3 edges after acceptance.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    bit ev;
    g = -1;
    if (!rst && q.size() < D) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ev = (q.size() > 0) && (q[0].ready <= ecnt);
    s_rst = rst;
    s_hs  = (g >= 0);
    s_idx = g;
    if (g >= 0) begin
      s_a  = req_a[16*g +: 16];
      s_b  = req_b[16*g +: 16];
      s_op = req_op[g];
    end
    s_pop = ev && resp_ready;
    if (chk_on) begin
      check("req_ready", 32'(req_ready), 32'(er));
      check("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        check("resp_id", 32'(resp_id), q[0].id);
        check("resp_data", 32'(resp_data), 32'(q[0].data));
      end
      check("busy", 32'(busy), 32'(q.size() != 0));
      check("fu_a", 32'(fu_a), 32'(m_fu_a));
      check("fu_b", 32'(fu_b), 32'(m_fu_b));
      check("fu_op", 32'(fu_op), 32'(m_fu_op));
    end
  end

  always @(posedge clk) begin
    ent_t e;
    if (s_rst) begin
      q.delete();
      m_rr    = N - 1;
      m_fu_a  = '0;
      m_fu_b  = '0;
      m_fu_op = 1'b0;
      chk_on  = 1'b1;
    end else begin
      if (s_pop) void'(q.pop_front());
      if (s_hs) begin
        e.id    = s_idx;
        e.data  = fu_fn(s_a, s_b, s_op);
        e.ready = ecnt + 3;
        q.push_back(e);
        m_rr    = s_idx;
        m_fu_a  = s_a;
        m_fu_b  = s_b;
        m_fu_op = s_op;
      end
    end
    ecnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp_g[6];
    int acc, pops, g;
    bit stalled;
    logic [19:0] hd;
    logic [1:0] hi;
    exp_g = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_fu_a", 32'(fu_a), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single op latency and data
    req_a[15:0] = 16'h3E00; req_b[15:0] = 16'h3E00; req_op[0] = 1'b0;
    req_valid = 4'b0001; resp_ready = 1'b1;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    tick(1);
    req_valid = '0;
    check("t1_fu_a", 32'(fu_a), 32'h3E00);
    tick(1);
    check("t1_not_yet", 32'(resp_valid), 32'd0);
    tick(1);
    check("t1_valid", 32'(resp_valid), 32'd1);
    check("t1_id", 32'(resp_id), 32'd0);
    check("t1_data", 32'(resp_data), 32'h40800);
    tick(2);

    // Round-robin with all requesting
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'h1000 + 16'(i) * 16'h0111;
      req_b[16*i +: 16] = 16'h2000 + 16'(i);
      req_op[i] = i[0];
    end
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      g = -1;
      for (int j = 0; j < N; j++) if (req_ready[j]) g = j;
      check("rr_grant", g, exp_g[k]);
      if (k >= 3) begin
        check("rr_resp_valid", 32'(resp_valid), 32'd1);
        check("rr_resp_id", 32'(resp_id), exp_g[k-3]);
      end
      tick(1);
    end
    req_valid = '0;
    tick(6);

    // Backpressure and credit
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      req_a[47:32] = 16'h4000 + 16'(k);
      req_b[47:32] = 16'h0100 * 16'(k);
      #1 if (req_ready[2]) acc++;
      tick(1);
    end
    check("bp_accepts", acc, 4);
    check("bp_blocked", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    #1 check("bp_ready_pop_cycle", 32'(req_ready), 32'd0);
    tick(1);
    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      req_a[47:32] = 16'h5000 + 16'(k);
      #1 if (req_ready[2]) acc++;
      tick(1);
    end
    check("bp_one_more", acc, 1);
    req_valid = '0;
    resp_ready = 1'b1;
    tick(8);

    // Special operand passthrough
    req_a[31:16] = 16'hFFFF; req_b[31:16] = 16'h3E00; req_op[1] = 1'b1;
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    tick(2);
    check("sp_valid", 32'(resp_valid), 32'd1);
    check("sp_id", 32'(resp_id), 32'd1);
    check("sp_data", 32'(resp_data), 32'h0FFFF);
    tick(2);

    // Reset with ops in flight
    req_valid = 4'b0001;
    tick(2);
    rst = 1'b1;
    req_valid = '0;
    tick(1);
    rst = 1'b0;
    check("mr_resp_valid", 32'(resp_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("mr_stays_empty", 32'(resp_valid), 32'd0);
    end
    req_valid = '1;
    #1 check("mr_grant0", 32'(req_ready), 32'h1);
    tick(1);
    req_valid = '0;
    tick(5);

    // Hold stability under toggling backpressure
    resp_ready = 1'b0;
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      req_a[63:48] = 16'h6000 + 16'(k) * 16'h0123;
      req_b[63:48] = 16'h0A00 + 16'(k);
      req_op[3] = k[0];
      tick(1);
    end
    req_valid = '0;
    tick(3);
    check("hs_valid", 32'(resp_valid), 32'd1);
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      resp_ready = k[0];
      #1;
      stalled = resp_valid && !resp_ready;
      if (resp_valid && resp_ready) pops++;
      hd = resp_data;
      hi = resp_id;
      tick(1);
      if (stalled) begin
        check("hold_data", 32'(resp_data), 32'(hd));
        check("hold_id", 32'(resp_id), 32'(hi));
      end
    end
    check("hs_pops", pops, 3);
    resp_ready = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
